// File: rtl/sram_ctrl.sv
`timescale 1ns/1ps
// sram_ctrl: single-word request to asynchronous SRAM cycle sequencer.
// Reads hold ce_n/oe_n low for WAIT_CYCLES cycles; writes use setup,
// a WAIT_CYCLES-long we_n pulse and a hold cycle. All strobes are registered.
module sram_ctrl #(
  parameter int unsigned ADDR_WIDTH  = 20,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  inout  wire  [31:0]           ram_data,
  output logic                  ram_ce_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n
);

  localparam int unsigned CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             wdata_q, wdata_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    ce_n_q, ce_n_d;
  logic                    oe_n_q, oe_n_d;
  logic                    we_n_q, we_n_d;
  logic                    drive_q, drive_d;

  // Next-state logic; strobes are decoded from the next state so that they
  // leave a flop in the same cycle the state register changes.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_valid_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = '0;
          state_d = req_we ? S_WR_SETUP : S_RD;
        end
      end
      S_RD: begin
        if (cnt_q == CNT_LAST) begin
          rdata_d      = ram_data;
          resp_valid_d = 1'b1;
          cnt_d        = '0;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_SETUP: begin
        cnt_d   = '0;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WR_HOLD: begin
        resp_valid_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    ce_n_d  = (state_d == S_IDLE);
    oe_n_d  = (state_d != S_RD);
    we_n_d  = (state_d != S_WR_PULSE);
    drive_d = (state_d == S_WR_SETUP) || (state_d == S_WR_PULSE) ||
              (state_d == S_WR_HOLD);
  end

  // State, datapath and strobe registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      resp_valid_q <= 1'b0;
      ce_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      drive_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_valid_q <= resp_valid_d;
      ce_n_q       <= ce_n_d;
      oe_n_q       <= oe_n_d;
      we_n_q       <= we_n_d;
      drive_q      <= drive_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign ram_addr   = addr_q;
  assign ram_ce_n   = ce_n_q;
  assign ram_oe_n   = oe_n_q;
  assign ram_we_n   = we_n_q;
  assign ram_data   = drive_q ? wdata_q : 'z;

  a_oe_we_exclusive: assert property (@(posedge clk) disable iff (rst)
    !(!ram_oe_n && !ram_we_n));

  a_no_drive_on_read: assert property (@(posedge clk) disable iff (rst)
    !(!ram_oe_n && drive_q));

  a_we_fall_setup: assert property (@(posedge clk) disable iff (rst)
    $fell(ram_we_n) |-> (!ram_ce_n && $stable(ram_addr) && $stable(wdata_q) &&
                         $past(drive_q)));

endmodule

// File: tb/tb_sram_ctrl.sv
`timescale 1ns/1ps
// Bench for sram_ctrl: two instances (WAIT_CYCLES 1 and 3), each attached
// to a behavioural asynchronous SRAM that commits on the we_n falling edge.
module tb_sram_ctrl;
  localparam int unsigned AW = 20;

  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_we, req_ready, resp_valid, ce_n, oe_n, we_n;
  logic [1:0][AW-1:0] req_addr, ram_addr;
  logic [1:0][31:0]   req_wdata, resp_rdata;
  wire  [31:0]        ram_data_a, ram_data_b;

  logic [1:0]        rd_en;
  logic [1:0][31:0]  rd_val;
  logic [1:0]        we_last = 2'b11;
  logic [31:0]       mem [int unsigned];

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;

  typedef struct {
    int unsigned d;
    bit          rd;
    logic [31:0] data;
    int unsigned due;
  } sb_t;
  sb_t sbq[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  sram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(1)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .ram_addr(ram_addr[0]), .ram_data(ram_data_a),
    .ram_ce_n(ce_n[0]), .ram_oe_n(oe_n[0]), .ram_we_n(we_n[0])
  );

  sram_ctrl #(.ADDR_WIDTH(AW), .WAIT_CYCLES(3)) u_dut_w3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .ram_addr(ram_addr[1]), .ram_data(ram_data_b),
    .ram_ce_n(ce_n[1]), .ram_oe_n(oe_n[1]), .ram_we_n(we_n[1])
  );

  assign ram_data_a = rd_en[0] ? rd_val[0] : 'z;
  assign ram_data_b = rd_en[1] ? rd_val[1] : 'z;

  function automatic int unsigned key(input int unsigned d, input logic [AW-1:0] a);
    return {11'd0, d[0], a};
  endfunction

  // SRAM model: commit on we_n falling edge while selected; drive on read.
  always @(we_n or oe_n or ce_n or ram_addr) begin
    for (int d = 0; d < 2; d++) begin
      int unsigned k;
      k = key(d, ram_addr[d]);
      if (we_last[d] && !we_n[d] && !ce_n[d])
        mem[k] = (d == 0) ? ram_data_a : ram_data_b;
      we_last[d] = we_n[d];
      rd_en[d]   = !ce_n[d] && !oe_n[d] && we_n[d];
      rd_val[d]  = mem.exists(k) ? mem[k] : '0;
    end
  end

  task automatic monitor();
    logic [31:0] dv;
    forever begin
      @(negedge clk);
      if (!rst) begin
        for (int d = 0; d < 2; d++) begin
          n_checks++;
          if (!oe_n[d] && !we_n[d])
            $display("FAIL strobe_overlap dut%0d: oe_n=0 we_n=0 at cycle %0d, required never both low", d, cyc);
          else n_pass++;
          if (!oe_n[d]) begin
            dv = (d == 0) ? ram_data_a : ram_data_b;
            n_checks++;
            if (dv !== rd_val[d])
              $display("FAIL bus_contention dut%0d: ram_data=%h, required SRAM value %h", d, dv, rd_val[d]);
            else n_pass++;
          end
        end
      end
    end
  endtask

  task automatic issue(input int unsigned d, input bit we, input logic [AW-1:0] a,
                       input logic [31:0] w, input logic [31:0] exp);
    int unsigned lat;
    lat = (we ? 2 : 0) + ((d == 0) ? 1 : 3);
    req_we[d] = we; req_addr[d] = a; req_wdata[d] = w; req_valid[d] = 1'b1;
    for (int i = 0; i < 50 && !req_ready[d]; i++) @(negedge clk);
    sbq.push_back('{d, !we, exp, cyc + 1 + lat});
    @(negedge clk);
    req_valid[d] = 1'b0;
  endtask

  task automatic wait_resp(input int unsigned d, output bit ok, output int unsigned ce_lo,
                           output int unsigned oe_lo, output int unsigned we_lo);
    ok = 1'b0; ce_lo = 0; oe_lo = 0; we_lo = 0;
    for (int i = 0; i < 50; i++) begin
      if (resp_valid[d]) begin
        ok = 1'b1;
        break;
      end
      if (!ce_n[d]) ce_lo++;
      if (!oe_n[d]) oe_lo++;
      if (!we_n[d]) we_lo++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if (req_ready !== 2'b11 || resp_valid !== 2'b00)
      $display("FAIL reset_handshake: ready=%b resp_valid=%b, required 11/00", req_ready, resp_valid);
    else n_pass++;
    n_checks++;
    if (resp_rdata[0] !== '0 || resp_rdata[1] !== '0)
      $display("FAIL reset_rdata: %h %h, required 0", resp_rdata[0], resp_rdata[1]);
    else n_pass++;
    n_checks++;
    if (ram_addr[0] !== '0 || ram_addr[1] !== '0)
      $display("FAIL reset_addr: %h %h, required 0", ram_addr[0], ram_addr[1]);
    else n_pass++;
    n_checks++;
    if ({ce_n, oe_n, we_n} !== 6'b111111)
      $display("FAIL reset_strobes: ce/oe/we=%b, required 111111", {ce_n, oe_n, we_n});
    else n_pass++;
  endtask

  task automatic test_basic();
    bit ok; int unsigned ce_lo, oe_lo, we_lo; sb_t e;
    issue(0, 1'b1, 20'h00010, 32'hDEADBEEF, 32'h0);
    wait_resp(0, ok, ce_lo, oe_lo, we_lo);
    e = sbq.pop_front();
    n_checks++;
    if (!ok || cyc !== e.due)
      $display("FAIL w1_write_latency: ok=%0d cycle %0d, required %0d", ok, cyc, e.due);
    else n_pass++;
    n_checks++;
    if (we_lo !== 1 || ce_lo !== 3 || oe_lo !== 0)
      $display("FAIL w1_write_strobes: ce_lo=%0d oe_lo=%0d we_lo=%0d, required 3/0/1", ce_lo, oe_lo, we_lo);
    else n_pass++;
    n_checks++;
    if (resp_rdata[0] !== e.data || req_ready[0] !== 1'b1)
      $display("FAIL w1_write_resp: rdata=%h ready=%b, required %h/1", resp_rdata[0], req_ready[0], e.data);
    else n_pass++;
    n_checks++;
    if (!mem.exists(key(0, 20'h00010)) || mem[key(0, 20'h00010)] !== 32'hDEADBEEF)
      $display("FAIL w1_mem_store: value missing or wrong, required DEADBEEF");
    else n_pass++;
    issue(0, 1'b0, 20'h00010, 32'h0, 32'hDEADBEEF);
    wait_resp(0, ok, ce_lo, oe_lo, we_lo);
    e = sbq.pop_front();
    n_checks++;
    if (!ok || cyc !== e.due || oe_lo !== 1)
      $display("FAIL w1_read_latency: ok=%0d cycle %0d oe_lo=%0d, required %0d/1", ok, cyc, oe_lo, e.due);
    else n_pass++;
    n_checks++;
    if (resp_rdata[0] !== e.data)
      $display("FAIL w1_read_data: %h, required %h", resp_rdata[0], e.data);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (resp_valid[0] !== 1'b0 || resp_rdata[0] !== 32'hDEADBEEF)
      $display("FAIL w1_resp_pulse: resp_valid=%b rdata=%h, required 0/DEADBEEF", resp_valid[0], resp_rdata[0]);
    else n_pass++;
  endtask

  task automatic test_wait3();
    bit ok; int unsigned ce_lo, oe_lo, we_lo; sb_t e;
    issue(1, 1'b1, 20'hFFFFF, 32'h12345678, 32'h0);
    wait_resp(1, ok, ce_lo, oe_lo, we_lo);
    e = sbq.pop_front();
    n_checks++;
    if (!ok || cyc !== e.due || we_lo !== 3 || ce_lo !== 5)
      $display("FAIL w3_write: ok=%0d cycle %0d we_lo=%0d ce_lo=%0d, required %0d/3/5", ok, cyc, we_lo, ce_lo, e.due);
    else n_pass++;
    issue(1, 1'b0, 20'hFFFFF, 32'h0, 32'h12345678);
    wait_resp(1, ok, ce_lo, oe_lo, we_lo);
    e = sbq.pop_front();
    n_checks++;
    if (!ok || cyc !== e.due || oe_lo !== 3 || we_lo !== 0)
      $display("FAIL w3_read_timing: ok=%0d cycle %0d oe_lo=%0d we_lo=%0d, required %0d/3/0", ok, cyc, oe_lo, we_lo, e.due);
    else n_pass++;
    n_checks++;
    if (resp_rdata[1] !== e.data)
      $display("FAIL w3_read_data: %h, required %h", resp_rdata[1], e.data);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int unsigned i = 0, nresp = 0, guard = 0;
    logic [31:0] exp_rd = 32'hDEADBEEF;
    sb_t e;
    while (nresp < 6 && guard < 200) begin
      if (resp_valid[0]) begin
        n_checks++;
        if (sbq.size() == 0) begin
          $display("FAIL b2b_extra_resp: response at cycle %0d, required none outstanding", cyc);
        end else begin
          e = sbq.pop_front();
          if (cyc !== e.due || resp_rdata[0] !== e.data)
            $display("FAIL b2b_resp%0d: cycle %0d rdata %h, required %0d/%h", nresp, cyc, resp_rdata[0], e.due, e.data);
          else n_pass++;
        end
        nresp++;
      end
      if (i < 6) begin
        req_valid[0] = 1'b1;
        req_we[0]    = (i % 2 == 0);
        req_addr[0]  = 20'h00005;
        req_wdata[0] = 32'hA5A5A5A5;
        if (req_ready[0]) begin
          if (i > 0) begin
            n_checks++;
            if (resp_valid[0] !== 1'b1)
              $display("FAIL b2b_accept%0d: resp_valid=%b at accept, required 1", i, resp_valid[0]);
            else n_pass++;
          end
          if (i % 2 == 1) exp_rd = 32'hA5A5A5A5;
          sbq.push_back('{0, (i % 2 == 1), exp_rd, cyc + 1 + ((i % 2 == 0) ? 3 : 1)});
          i++;
        end
      end else begin
        req_valid[0] = 1'b0;
      end
      @(negedge clk);
      guard++;
    end
    req_valid[0] = 1'b0;
    n_checks++;
    if (nresp !== 6 || sbq.size() !== 0)
      $display("FAIL b2b_count: responses %0d outstanding %0d, required 6/0", nresp, sbq.size());
    else n_pass++;
  endtask

  task automatic test_capture();
    bit ok; int unsigned ce_lo, oe_lo, we_lo; sb_t e;
    issue(1, 1'b1, 20'h00333, 32'h0BADF00D, 32'h12345678);
    req_addr[1]  = 20'h00444;
    req_wdata[1] = 32'hFFFF0000;
    wait_resp(1, ok, ce_lo, oe_lo, we_lo);
    e = sbq.pop_front();
    n_checks++;
    if (!ok || cyc !== e.due || ram_addr[1] !== 20'h00333)
      $display("FAIL capture_addr: ok=%0d cycle %0d addr %h, required %0d/00333", ok, cyc, ram_addr[1], e.due);
    else n_pass++;
    n_checks++;
    if (!mem.exists(key(1, 20'h00333)) || mem[key(1, 20'h00333)] !== 32'h0BADF00D ||
        mem.exists(key(1, 20'h00444)))
      $display("FAIL capture_store: accepted write not stored as 0BADF00D at 00333 only");
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit ok; int unsigned ce_lo, oe_lo, we_lo; sb_t e; bit seen;
    logic [31:0] dv;
    issue(0, 1'b1, 20'h00020, 32'h11112222, 32'hA5A5A5A5);
    wait_resp(0, ok, ce_lo, oe_lo, we_lo);
    e = sbq.pop_front();
    n_checks++;
    if (!ok || cyc !== e.due || resp_rdata[0] !== e.data)
      $display("FAIL pre_reset_write: ok=%0d cycle %0d rdata %h, required %0d/%h", ok, cyc, resp_rdata[0], e.due, e.data);
    else n_pass++;
    // reset while in RD
    issue(0, 1'b0, 20'h00020, 32'h0, 32'h0);
    rst = 1'b1;
    #1;
    void'(sbq.pop_back());
    n_checks++;
    if ({ce_n[0], oe_n[0], we_n[0]} !== 3'b111 || resp_valid[0] !== 1'b0 || resp_rdata[0] !== '0)
      $display("FAIL reset_in_read: strobes=%b resp_valid=%b rdata=%h, required 111/0/0",
               {ce_n[0], oe_n[0], we_n[0]}, resp_valid[0], resp_rdata[0]);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (resp_valid[0]) seen = 1'b1; end
    n_checks++;
    if (seen) $display("FAIL reset_in_read_resp: resp_valid=1 after reset, required 0");
    else n_pass++;
    // reset while in WR_SETUP
    issue(0, 1'b1, 20'h00020, 32'h33334444, 32'h0);
    rst = 1'b1;
    #1;
    void'(sbq.pop_back());
    dv = ram_data_a;
    n_checks++;
    if ({ce_n[0], oe_n[0], we_n[0]} !== 3'b111 || (dv !== 'z && dv !== '0))
      $display("FAIL reset_in_setup: strobes=%b ram_data=%h, required 111/high-Z",
               {ce_n[0], oe_n[0], we_n[0]}, dv);
    else n_pass++;
    @(negedge clk); rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin @(negedge clk); if (resp_valid[0]) seen = 1'b1; end
    n_checks++;
    if (seen || mem[key(0, 20'h00020)] !== 32'h11112222)
      $display("FAIL reset_in_setup_mem: resp=%b mem=%h, required 0/11112222", seen, mem[key(0, 20'h00020)]);
    else n_pass++;
    issue(0, 1'b0, 20'h00020, 32'h0, 32'h11112222);
    wait_resp(0, ok, ce_lo, oe_lo, we_lo);
    e = sbq.pop_front();
    n_checks++;
    if (!ok || cyc !== e.due || resp_rdata[0] !== e.data)
      $display("FAIL post_reset_read: ok=%0d cycle %0d rdata %h, required %0d/%h", ok, cyc, resp_rdata[0], e.due, e.data);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    #1;
    test_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    fork
      monitor();
    join_none
    @(negedge clk);
    test_basic();
    test_wait3();
    test_back_to_back();
    test_capture();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
